// File: rtl/datapath_seq_pkg.sv
// datapath_seq_pkg: shared instruction layout, kinds and ALU opcodes for the datapath sequencer.
package datapath_seq_pkg;
   typedef enum logic [1:0] {K_NOP, K_LOAD, K_EXEC, K_RSVD} kind_e;
   typedef struct packed {
      kind_e      kind;
      logic [2:0] op;
      logic [3:0] sel;
      logic [3:0] wa;
      logic [3:0] raa;
      logic [3:0] rab;
   } ctrl_t;
   typedef struct packed {
      ctrl_t ctrl;
      logic  rsvd;
   } instr_t;
   localparam logic [2:0] OP_MOV = 3'd4;
   localparam logic [2:0] OP_SHR = 3'd1;
endpackage

// File: rtl/datapath_seq_if.sv
// datapath_seq_if: instruction in / result out handshake bundle between host and sequencer.
interface datapath_seq_if;
   import datapath_seq_pkg::*;
   logic       ins_valid;
   logic       ins_ready;
   instr_t     ins_data;
   logic       res_valid;
   logic       res_ready;
   logic [6:0] res_data;
   logic       res_flag;
   modport master (output ins_valid, ins_data, res_ready, input ins_ready, res_valid, res_data, res_flag);
   modport slave  (input ins_valid, ins_data, res_ready, output ins_ready, res_valid, res_data, res_flag);
endinterface

// File: rtl/datapath_seq_fifo.sv
// datapath_seq_fifo: power-of-two instruction FIFO; caller gates push with !full and pop with !empty.
module datapath_seq_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 21
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [AW:0]   cnt_q, cnt_d;
   always_comb begin
      wp_d  = push ? wp_q + 1'b1 : wp_q;
      rp_d  = pop ? rp_q + 1'b1 : rp_q;
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wp_q] <= din;
   end
   assign full  = cnt_q == (AW+1)'(DEPTH);
   assign empty = cnt_q == '0;
   assign dout  = mem_q[rp_q];
endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: issues one registered control word per cycle from an instruction FIFO and
// returns EXEC results over valid/ready. DATAPATH_SEQ_PERF_EN adds perf_issued/perf_stalls counters.
module datapath_sequencer
   import datapath_seq_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int INSTR_W = 22
) (
   input  logic       clk,
   input  logic       rst,
   datapath_seq_if.slave bus,
   output logic       busy,
   output logic [3:0] Sel,
   output logic       Wen,
   output logic [3:0] WA,
   output logic [3:0] RAA,
   output logic [3:0] RAB,
   output logic [2:0] Op,
   input  logic [6:0] OutPort,
   input  logic       Flag
`ifdef DATAPATH_SEQ_PERF_EN
   ,
   output logic [15:0] perf_issued,
   output logic [15:0] perf_stalls
`endif
);
   logic               full, empty, push, pop, stall, take, is_load, is_exec;
   logic [INSTR_W-2:0] head_raw;
   ctrl_t              head;
   logic [3:0]         sel_q, sel_d, wa_q, wa_d, raa_q, raa_d, rab_q, rab_d;
   logic [2:0]         op_q, op_d;
   logic               wen_q, wen_d, exec_q, exec_d;
   logic               res_valid_q, res_valid_d, skid_valid_q, skid_valid_d;
   logic [7:0]         res_q, res_d, skid_q, skid_d;

   datapath_seq_fifo #(.DEPTH(DEPTH), .W(INSTR_W-1)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (bus.ins_data.ctrl),
      .dout  (head_raw),
      .full  (full),
      .empty (empty)
   );
   assign head = ctrl_t'(head_raw);

   // the skid slot catches an EXEC capture that lands while the previous result is still held
   always_comb begin
      stall        = res_valid_q && !bus.res_ready;
      take         = res_valid_q && bus.res_ready;
      pop          = !empty && !stall;
      push         = bus.ins_valid && !full;
      is_load      = pop && head.kind == K_LOAD;
      is_exec      = pop && head.kind == K_EXEC;
      wen_d        = is_load;
      exec_d       = is_exec;
      sel_d        = is_load ? head.sel : sel_q;
      wa_d         = is_load ? head.wa : wa_q;
      op_d         = is_exec ? head.op : op_q;
      raa_d        = is_exec ? head.raa : raa_q;
      rab_d        = is_exec ? head.rab : rab_q;
      res_valid_d  = exec_q || skid_valid_q || stall;
      res_d        = stall ? res_q : skid_valid_q ? skid_q : exec_q ? {Flag, OutPort} : res_q;
      skid_valid_d = skid_valid_q ? stall : exec_q && stall;
      skid_d       = (exec_q && !skid_valid_q) ? {Flag, OutPort} : skid_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q        <= '0;
         wa_q         <= '0;
         raa_q        <= '0;
         rab_q        <= '0;
         op_q         <= '0;
         wen_q        <= 1'b0;
         exec_q       <= 1'b0;
         res_valid_q  <= 1'b0;
         res_q        <= '0;
         skid_valid_q <= 1'b0;
         skid_q       <= '0;
      end else begin
         sel_q        <= sel_d;
         wa_q         <= wa_d;
         raa_q        <= raa_d;
         rab_q        <= rab_d;
         op_q         <= op_d;
         wen_q        <= wen_d;
         exec_q       <= exec_d;
         res_valid_q  <= res_valid_d;
         res_q        <= res_d;
         skid_valid_q <= skid_valid_d;
         skid_q       <= skid_d;
      end
   end

   assign bus.ins_ready = !full;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_q[6:0];
   assign bus.res_flag  = res_q[7];
   assign busy          = !empty || res_valid_q;
   assign Sel           = sel_q;
   assign Wen           = wen_q;
   assign WA            = wa_q;
   assign RAA           = raa_q;
   assign RAB           = rab_q;
   assign Op            = op_q;

`ifdef DATAPATH_SEQ_PERF_EN
   logic [15:0] issued_q, issued_d, stalls_q, stalls_d;
   always_comb begin
      issued_d = ((is_load || is_exec) && issued_q != 16'hFFFF) ? issued_q + 16'd1 : issued_q;
      stalls_d = (!empty && stall && stalls_q != 16'hFFFF) ? stalls_q + 16'd1 : stalls_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         issued_q <= '0;
         stalls_q <= '0;
      end else begin
         issued_q <= issued_d;
         stalls_q <= stalls_d;
      end
   end
   assign perf_issued = issued_q;
   assign perf_stalls = stalls_q;
`endif
endmodule
